// File: rtl/shift_unit_seq.sv
// -----------------------------------------------------------------------------
// shift_unit_seq
//   Sequential shift/rotate unit. Loads a WIDTH-bit word and applies a shift
//   or rotate of a programmable amount. It moves one bit position per clock
//   and marks completion with a one-cycle done pulse.
//
// Parameters
//   WIDTH  data width in bits (>= 2)
//   AMT_W  width of the shift-amount field
//
// Ports
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  request, only sampled while idle
//   i_mode   operation code, latched on accept
//            000 hold, 001 SHL, 010 SHR, 011 ROTL, 100 ROTR, 101 ASR,
//            110 LOAD, 111 reserved (hold)
//   i_amt    number of single-bit steps, latched on accept
//   i_din    operand, loaded on accept for shift modes and LOAD
//   i_sin    serial fill bit for logical shifts, sampled on every step
//   o_dout   working register, visible at all times
//   o_sout   bit most recently shifted or rotated out
//   o_busy   high while stepping
//   o_done   one-cycle completion pulse
//
// Configuration macro
//   SHIFTREG_ROTATE_EN  when defined, modes 011/100 rotate. When undefined,
//                       the rotate logic is absent and those codes act as
//                       reserved (hold).
// -----------------------------------------------------------------------------
module shift_unit_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [AMT_W-1:0] i_amt,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ROTL = 3'b011;
  localparam logic [2:0] M_ROTR = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  logic [1:0]       r_state;
  logic [2:0]       r_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_sout;
  logic             w_is_shift;
  logic [WIDTH:0]   w_step;

  // One single-bit step. Result is {bit shifted out, new register}.
  function automatic logic [WIDTH:0] f_step(input logic [2:0]       mode,
                                            input logic [WIDTH-1:0] data,
                                            input logic             sin,
                                            input logic             sout);
    logic [WIDTH:0] res;
    res = {sout, data};
    case (mode)
      M_SHL:  res = {data[WIDTH-1], data[WIDTH-2:0], sin};
      M_SHR:  res = {data[0], sin, data[WIDTH-1:1]};
      M_ASR:  res = {data[0], data[WIDTH-1], data[WIDTH-1:1]};
`ifdef SHIFTREG_ROTATE_EN
      M_ROTL: res = {data[WIDTH-1], data[WIDTH-2:0], data[WIDTH-1]};
      M_ROTR: res = {data[0], data[0], data[WIDTH-1:1]};
`endif
      default: res = {sout, data};
    endcase
    return res;
  endfunction

  // Modes that load din and step; without the rotate option, the rotate
  // codes fall into the hold/reserved group.
  always_comb begin
    w_is_shift = 1'b0;
    case (i_mode)
      M_SHL, M_SHR, M_ASR: w_is_shift = 1'b1;
`ifdef SHIFTREG_ROTATE_EN
      M_ROTL, M_ROTR:      w_is_shift = 1'b1;
`endif
      default:             w_is_shift = 1'b0;
    endcase
  end

  assign w_step = f_step(r_mode, r_data, i_sin, r_sout);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= M_HOLD;
      r_cnt   <= '0;
      r_data  <= '0;
      r_sout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode <= i_mode;
            r_cnt  <= i_amt;
            if (w_is_shift) begin
              r_data  <= i_din;
              r_state <= (i_amt != '0) ? S_SHIFT : S_DONE;
            end else begin
              if (i_mode == M_LOAD) begin
                r_data <= i_din;
              end
              r_state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          {r_sout, r_data} <= w_step;
          r_cnt            <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dout = r_data;
  assign o_sout = r_sout;
  assign o_busy = (r_state == S_SHIFT);
  assign o_done = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_seq
//   Self-checking bench for shift_unit_seq. Runs directed and randomized
//   operations and compares them against a closed-form reference model.
//   This bench honours SHIFTREG_ROTATE_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_shift_unit_seq;

  localparam int W  = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  din;
  logic          sin;
  logic [W-1:0]  dout;
  logic          sout;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] prev_dout;
  logic         prev_sout;

  always #5 clk = ~clk;

  shift_unit_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_mode (mode),
    .i_amt  (amt),
    .i_din  (din),
    .i_sin  (sin),
    .o_dout (dout),
    .o_sout (sout),
    .o_busy (busy),
    .o_done (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_shift(input logic [2:0] m);
    bit r;
    r = (m == 3'b001) || (m == 3'b010) || (m == 3'b101);
`ifdef SHIFTREG_ROTATE_EN
    r = r || (m == 3'b011) || (m == 3'b100);
`endif
    return r;
  endfunction

  // Register contents and last out-bit after k steps of mode m on operand d,
  // written as whole-word arithmetic rather than step by step.
  task automatic model(input logic [2:0] m, input logic [W-1:0] d, input logic s,
                       input int k, input logic ps,
                       output logic [W-1:0] od, output logic os);
    logic [W-1:0]        ones;
    logic signed [W-1:0] sd;
    int                  r;
    ones = '1;
    sd   = d;
    r    = k % W;
    od   = d;
    os   = ps;
    if (k > 0) begin
      case (m)
        3'b001: begin
          od = (d << k) | (s ? ~(ones << k) : '0);
          os = (k <= W) ? d[W-k] : s;
        end
        3'b010: begin
          od = (d >> k) | (s ? ~(ones >> k) : '0);
          os = (k <= W) ? d[k-1] : s;
        end
        3'b011: begin
          od = (d << r) | (d >> (W - r));
          os = d[(W - r) % W];
        end
        3'b100: begin
          od = (d >> r) | (d << (W - r));
          os = d[(k - 1) % W];
        end
        3'b101: begin
          od = sd >>> k;
          os = (k <= W) ? d[k-1] : d[W-1];
        end
        default: begin
          od = d;
          os = ps;
        end
      endcase
    end
  endtask

  // Called at a falling edge while the DUT is idle. Returns at a falling
  // edge in the first idle cycle after the operation.
  task automatic run_op(input logic [2:0] m, input int k, input logic [W-1:0] d,
                        input logic s, input bit hold_start);
    int           lat;
    bit           sh;
    logic [W-1:0] ed;
    logic         es;
    sh  = is_shift(m);
    lat = (sh && k > 0) ? k + 1 : 1;
    start = 1'b1;
    mode  = m;
    amt   = AW'(k);
    din   = d;
    sin   = s;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    for (int j = 1; j <= lat; j++) begin
      if (sh) begin
        model(m, d, s, j - 1, prev_sout, ed, es);
      end else begin
        ed = (m == 3'b110) ? d : prev_dout;
        es = prev_sout;
      end
      chk($sformatf("dout m%0d k%0d c%0d", m, k, j), dout, ed);
      chk($sformatf("sout m%0d k%0d c%0d", m, k, j), sout, es);
      chk($sformatf("busy m%0d k%0d c%0d", m, k, j), busy, (j < lat));
      chk($sformatf("done m%0d k%0d c%0d", m, k, j), done, (j == lat));
      if (hold_start) begin
        // Requests while busy must be ignored.
        mode = 3'($urandom);
        din  = W'($urandom);
        amt  = AW'($urandom);
      end
      if (j == lat) start = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("idle_busy m%0d k%0d", m, k), busy, 1'b0);
    chk($sformatf("idle_done m%0d k%0d", m, k), done, 1'b0);
    chk($sformatf("idle_dout m%0d k%0d", m, k), dout, ed);
    prev_dout = ed;
    prev_sout = es;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = '0;
    amt   = '0;
    din   = '0;
    sin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_sout", sout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    prev_dout = '0;
    prev_sout = 1'b0;

    // Directed cases
    run_op(3'b001, 1, 4'b1011, 1'b0, 1'b0);
    chk("tp_shl_dout", dout, 4'b0110);
    chk("tp_shl_sout", sout, 1'b1);
    run_op(3'b101, 2, 4'b1001, 1'b0, 1'b0);
    chk("tp_asr_dout", dout, 4'b1110);
    chk("tp_asr_sout", sout, 1'b0);
    run_op(3'b010, 3, 4'b0000, 1'b1, 1'b0);
    chk("tp_shr_dout", dout, 4'b1110);
    chk("tp_shr_sout", sout, 1'b0);
    run_op(3'b011, 5, 4'b1001, 1'b0, 1'b0);
`ifdef SHIFTREG_ROTATE_EN
    chk("tp_rotl_dout", dout, 4'b0011);
`else
    chk("tp_rotl_dout", dout, 4'b1110);
`endif
    run_op(3'b110, 3, 4'b1100, 1'b0, 1'b0);
    run_op(3'b000, 2, 4'b0101, 1'b1, 1'b0);
    chk("tp_hold_dout", dout, 4'b1100);
    run_op(3'b010, 7, 4'b1010, 1'b0, 1'b1);
    run_op(3'b101, 7, 4'b1000, 1'b0, 1'b0);
    run_op(3'b001, 7, 4'b0110, 1'b1, 1'b0);
    run_op(3'b111, 4, 4'b0011, 1'b0, 1'b0);

    // Reset in the middle of an operation
    start = 1'b1;
    mode  = 3'b001;
    amt   = AW'(5);
    din   = 4'b1011;
    sin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sout", sout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    prev_dout = '0;
    prev_sout = 1'b0;
    run_op(3'b001, 2, 4'b0111, 1'b1, 1'b0);
    chk("post_rst_op", dout, 4'b1111);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, 7), W'($urandom),
             1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised, clocked successor to the lab-4 4-bit combinational shifter. Loads a WIDTH-bit word and applies a multi-cycle shift or rotate of a programmable amount, one bit position per clock, signalling completion with a one-cycle `done` pulse. It sits between the switch/register front-end and the display/ALU datapath, and replaces the single-step mux shifter wherever repeated or arithmetic shifts are required.

## Interface
- `WIDTH`, 4: data width in bits, ≥2.
- `AMT_W`, 3: width of the shift-amount field; amounts 0..2^AMT_W−1 are legal.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  3  operation code, latched on accept.
- `amt`  in  AMT_W  number of single-bit steps, latched on accept.
- `din`  in  WIDTH  operand, loaded on accept.
- `sin`  in  1  serial fill bit for logical shifts; sampled every step.
- `dout`  out  WIDTH  working register; always visible, including mid-operation.
- `sout`  out  1  bit most recently shifted or rotated out.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Modes:
  - 000 hold: register unchanged; `din` is not loaded.
  - 001 SHL: fill LSB with `sin`; MSB goes out.
  - 010 SHR: fill MSB with `sin`; LSB goes out.
  - 011 ROTL.
  - 100 ROTR.
  - 101 ASR: MSB replicated; LSB goes out.
  - 110 LOAD: `dout` ← `din`, no shifting.
  - 111 reserved: behaves as hold.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, `start`=1: latch `mode` and `amt`.
  - Modes 001–101: register ← `din`, counter ← `amt`. Go to SHIFT if `amt`≠0, else DONE.
  - Modes 000, 110, 111: go directly to DONE. 110 loads `din`; 000 and 111 do not.
- SHIFT: one step per clock, counter decrements. The step with counter=1 moves the FSM to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` in SHIFT or DONE is ignored; there is no queueing.
- Amounts ≥ WIDTH are legal:
  - Rotates wrap modulo WIDTH naturally.
  - Logical shifts fully flush with `sin`.
  - ASR saturates to all-sign.
- `sout` updates only on shift steps. It holds its value across hold/load operations.

## Timing
- Reset (async assert, release synchronised by the next edge): `dout`=0, `sout`=0, `busy`=0, `done`=0, counter=0, state IDLE.
- Reset asserted mid-operation aborts immediately; no `done` is produced.
- Accept on edge ending cycle N.
  - Shift modes, `amt`=k>0: `busy`=1 in cycles N+1..N+k; `done`=1 and the final `dout` in cycle N+k+1.
  - `amt`=0, or modes 000/110/111: `done`=1 in cycle N+1.
- Earliest next accept is cycle N+k+2 (the first IDLE cycle after DONE).
- `busy` and `done` are never high simultaneously.

## Configuration
- `SHIFTREG_ROTATE_EN` defined: modes 011 and 100 rotate as specified.
- `SHIFTREG_ROTATE_EN` undefined:
  - Rotate logic is omitted; 011 and 100 decode as reserved (hold, `done` at N+1, register and `sout` unchanged).
  - All other modes are identical.

## Test plan
- SHL, `din`=1011, `sin`=0, `amt`=1 → `done` at N+2 with `dout`=0110, `sout`=1; `busy` high only in N+1.
- ASR, `din`=1001, `amt`=2 → `dout` 1100 in N+2, then 1110 with `done` in N+3; `sout`=0.
- SHR, `din`=0000, `sin`=1, `amt`=3 → `dout` steps 1000, 1100, 1110; `done` in N+4; `sout`=0.
- ROTL, `din`=1001, `amt`=5 → `done` in N+6 with `dout`=0011.
  - With the macro undefined: `dout` keeps its prior value, `done` in N+1.
- LOAD `din`=1100, then HOLD with `din`=0101 → `dout` stays 1100. `start` pulsed during an `amt`=7 SHIFT is ignored: no extra `done`, no second operation.
- SHL, `din`=1011, `amt`=5; `rst_n` low during N+2 → `dout`=0000, `busy`=0 immediately; no `done` pulse; next `start` after release is accepted normally.
